// File: rtl/kernel3_fifo_srl_ctrl_if.sv
// rtl/kernel3_fifo_srl_ctrl_if.sv - producer/consumer handshake bundle for the SRL FIFO controller
interface kernel3_fifo_srl_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 1
);
   logic                  if_write_ce;
   logic                  if_write;
   logic [DATA_WIDTH-1:0] if_din;
   logic                  if_full_n;
   logic                  if_read_ce;
   logic                  if_read;
   logic [DATA_WIDTH-1:0] if_dout;
   logic                  if_empty_n;
   logic [ADDR_WIDTH:0]   if_num_data_valid;
   logic [ADDR_WIDTH:0]   if_fifo_cap;

   modport master (
      output if_write_ce, if_write, if_din, if_read_ce, if_read,
      input  if_full_n, if_dout, if_empty_n, if_num_data_valid, if_fifo_cap
   );

   modport slave (
      input  if_write_ce, if_write, if_din, if_read_ce, if_read,
      output if_full_n, if_dout, if_empty_n, if_num_data_valid, if_fifo_cap
   );
endinterface

// File: rtl/kernel3_fifo_srl_ctrl.sv
// rtl/kernel3_fifo_srl_ctrl.sv - occupancy, address and flag control for a shift-register FIFO
module kernel3_fifo_srl_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 1,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   kernel3_fifo_srl_ctrl_if.slave fifo,
   input  logic                  peak_clr,
   output logic [ADDR_WIDTH:0]   peak_usage,
   output logic                  shreg_we,
   output logic [ADDR_WIDTH-1:0] shreg_addr,
   output logic [DATA_WIDTH-1:0] shreg_din,
   input  logic [DATA_WIDTH-1:0] shreg_dout
);

   localparam logic [ADDR_WIDTH:0]   CAP      = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   USE_ZERO = '0;
   localparam logic [ADDR_WIDTH:0]   USE_ONE  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH:0]   usage, usage_next;
   logic [ADDR_WIDTH-1:0] addr_r, addr_next;
   logic [ADDR_WIDTH:0]   peak_r, peak_next;
   logic                  full_n_r, empty_n_r;
   logic                  push, pop;

   // Gating by the registered flags is what keeps usage within 0..DEPTH.
   assign push = fifo.if_write & fifo.if_write_ce & full_n_r;
   assign pop  = fifo.if_read  & fifo.if_read_ce  & empty_n_r;

   always_comb begin
      usage_next = usage;
      addr_next  = addr_r;
      if (push && !pop) begin
         usage_next = usage + USE_ONE;
         if (usage != USE_ZERO)
            addr_next = addr_r + ADDR_ONE;
      end else if (pop && !push) begin
         usage_next = usage - USE_ONE;
         if (usage > USE_ONE)
            addr_next = addr_r - ADDR_ONE;
      end
      // Simultaneous push/pop: the shift refills the head slot, so addr holds.
   end

   always_comb begin
      peak_next = peak_r;
      if (peak_clr)
         peak_next = usage_next;
      else if (usage_next > peak_r)
         peak_next = usage_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         usage     <= USE_ZERO;
         addr_r    <= '0;
         peak_r    <= USE_ZERO;
         full_n_r  <= 1'b1;
         empty_n_r <= 1'b0;
      end else begin
         usage     <= usage_next;
         addr_r    <= addr_next;
         peak_r    <= peak_next;
         full_n_r  <= (usage_next != CAP);
         empty_n_r <= (usage_next != USE_ZERO);
      end
   end

   assign shreg_we   = push;
   assign shreg_addr = addr_r;
   assign shreg_din  = fifo.if_din;
   assign peak_usage = peak_r;

   assign fifo.if_full_n         = full_n_r;
   assign fifo.if_empty_n        = empty_n_r;
   assign fifo.if_dout           = shreg_dout;
   assign fifo.if_num_data_valid = usage;
   assign fifo.if_fifo_cap       = CAP;

endmodule
